// File: rtl/clock_edge_monitor_if.sv
// Bundle between the divided-clock source, the monitor and its consumer.
// Master drives Clk_slow/Enable; slave (the monitor) drives the results.
interface clock_edge_monitor_if #(
  parameter int CNT_W = 8
);
  logic             Clk_slow;
  logic             Enable;
  logic             Rise_pulse;
  logic             Fall_pulse;
  logic [CNT_W-1:0] Period;
  logic             Period_valid;
  logic [CNT_W-1:0] High_time;
  logic             Timeout;

  modport master (
    output Clk_slow,
    output Enable,
    input  Rise_pulse,
    input  Fall_pulse,
    input  Period,
    input  Period_valid,
    input  High_time,
    input  Timeout
  );

  modport slave (
    input  Clk_slow,
    input  Enable,
    output Rise_pulse,
    output Fall_pulse,
    output Period,
    output Period_valid,
    output High_time,
    output Timeout
  );
endinterface

// File: rtl/clock_edge_monitor.sv
// Synchronizes a divided clock, emits edge strobes and measures its period.
// Define CLOCK_EDGE_MONITOR_HIGH_TIME_EN to also capture rise-to-fall time.
module clock_edge_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input logic                 Clock,
  input logic                 Reset,
  clock_edge_monitor_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  state_t           r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic             r_prev;
  logic             r_rise;
  logic             r_fall;
  logic             r_pv;
  logic             r_to;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;

  logic             w_s_last;
  logic             w_rise;
  logic             w_fall;
  logic             w_cnt_max;
  logic [CNT_W-1:0] w_cnt_p1;

  assign w_s_last  = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s_last & ~r_prev;
  assign w_fall    = ~w_s_last & r_prev;
  assign w_cnt_max = (r_cnt == MAX);
  assign w_cnt_p1  = w_cnt_max ? MAX : r_cnt + 1'b1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sync   <= '0;
      r_prev   <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_pv     <= 1'b0;
      r_to     <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_state  <= IDLE;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.Clk_slow};
      r_prev <= w_s_last;
      r_rise <= w_rise;
      r_fall <= w_fall;
      r_pv   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.Enable) r_state <= ARMED;
        end
        ARMED: begin
          r_cnt <= '0;
          if (!bus.Enable) begin
            r_state <= IDLE;
          end else if (w_rise) begin
            r_state <= MEASURE;
            r_to    <= 1'b0;
          end
        end
        MEASURE: begin
          if (!bus.Enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_rise) begin
            // a rise on the saturated count still completes the period
            r_period <= w_cnt_p1;
            r_pv     <= 1'b1;
            r_to     <= 1'b0;
            r_cnt    <= '0;
          end else if (w_cnt_max) begin
            r_to    <= 1'b1;
            r_state <= ARMED;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_p1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef CLOCK_EDGE_MONITOR_HIGH_TIME_EN
  logic [CNT_W-1:0] r_high;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_high <= '0;
    end else if (r_state == MEASURE && bus.Enable && w_fall) begin
      r_high <= w_cnt_p1;
    end
  end

  assign bus.High_time = r_high;
`else
  assign bus.High_time = '0;
`endif

  assign bus.Rise_pulse   = r_rise;
  assign bus.Fall_pulse   = r_fall;
  assign bus.Period       = r_period;
  assign bus.Period_valid = r_pv;
  assign bus.Timeout      = r_to;
endmodule

// File: tb/tb_clock_edge_monitor.sv
// Self-checking bench for clock_edge_monitor against a timestamp-based model.
// Honours CLOCK_EDGE_MONITOR_HIGH_TIME_EN for the expected High_time.
module tb_clock_edge_monitor;
  localparam int SS  = 2;
  localparam int CW  = 8;
  localparam int MAX = (1 << CW) - 1;
  localparam int OW  = 2 * CW + 4;
`ifdef CLOCK_EDGE_MONITOR_HIGH_TIME_EN
  localparam bit HT = 1'b1;
`else
  localparam bit HT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_edge_monitor_if #(.CNT_W(CW)) bus ();

  clock_edge_monitor #(
    .SYNC_STAGES(SS),
    .CNT_W      (CW)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // stimulus tables
  logic q_s[$];
  logic q_en[$];
  logic q_r[$];

  // reference model: sample history plus timestamps of the last rise
  logic          hist[$];
  int            tnow  = 0;
  int            tlast = 0;
  int            mode  = 0;
  logic          m_rise = 0, m_fall = 0, m_pv = 0, m_to = 0;
  logic [CW-1:0] m_per = '0, m_ht = '0;

  wire [OW-1:0] obs = {bus.Rise_pulse, bus.Fall_pulse, bus.Period_valid,
                       bus.Timeout, bus.Period, bus.High_time};
  wire [OW-1:0] expv = {m_rise, m_fall, m_pv, m_to, m_per, m_ht};

  function automatic logic [CW-1:0] sat(input int d);
    return (d > MAX) ? CW'(MAX) : CW'(d);
  endfunction

  task automatic model(input logic s, input logic en, input logic r);
    logic sn, sp, rs, fl;
    int   d;
    if (r) begin
      hist.delete();
      mode = 0;
      {m_rise, m_fall, m_pv, m_to} = 4'b0;
      m_per = '0;
      m_ht  = '0;
      return;
    end
    hist.push_front(s);
    if (hist.size() > SS + 2) void'(hist.pop_back());
    sn = (hist.size() > SS) ? hist[SS] : 1'b0;
    sp = (hist.size() > SS + 1) ? hist[SS+1] : 1'b0;
    rs = sn & ~sp;
    fl = ~sn & sp;
    m_rise = rs;
    m_fall = fl;
    m_pv   = 1'b0;
    d      = tnow - tlast;
    case (mode)
      0: if (en) mode = 1;
      1: begin
        if (!en) mode = 0;
        else if (rs) begin
          mode  = 2;
          tlast = tnow;
          m_to  = 1'b0;
        end
      end
      default: begin
        if (!en) mode = 0;
        else begin
          if (rs) begin
            m_per = sat(d);
            m_pv  = 1'b1;
            m_to  = 1'b0;
            tlast = tnow;
          end else if (d == MAX + 1) begin
            m_to = 1'b1;
            mode = 1;
          end
          if (fl && HT) m_ht = sat(d);
        end
      end
    endcase
  endtask

  task automatic step(input logic s, input logic en, input logic r);
    bus.Clk_slow = s;
    bus.Enable   = en;
    rst          = r;
    @(posedge clk);
    tnow++;
    model(s, en, r);
    #1;
  endtask

  task automatic push(input logic s, input logic en, input logic r);
    q_s.push_back(s);
    q_en.push_back(en);
    q_r.push_back(r);
  endtask

  task automatic clear_q();
    q_s.delete();
    q_en.delete();
    q_r.delete();
  endtask

  task automatic add_wave(input int hi, input int lo, input int n,
                          input logic en);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < hi; j++) push(1'b1, en, 1'b0);
      for (int j = 0; j < lo; j++) push(1'b0, en, 1'b0);
    end
  endtask

  task automatic test_reset();
    int nr = 0;
    clear_q();
    push(1'b1, 1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b1);
    push(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < q_s.size(); i++) begin
      step(q_s[i], q_en[i], q_r[i]);
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_zero cyc %0d got %h want 0", tnow, obs);
      end
    end
    clear_q();
    add_wave(2, 2, 4, 1'b0);
    for (int i = 0; i < q_s.size(); i++) begin
      step(q_s[i], q_en[i], q_r[i]);
      if (bus.Rise_pulse === 1'b1) nr++;
      checks++;
      if (obs !== expv || bus.Period_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_rel cyc %0d got %h want %h", tnow, obs, expv);
      end
    end
    checks++;
    if (nr !== 4) begin
      errors++;
      $display("FAIL reset_strobes got %0d rises want 4", nr);
    end
  endtask

  task automatic test_div2();
    clear_q();
    add_wave(1, 1, 12, 1'b1);
    for (int i = 0; i < q_s.size(); i++) begin
      step(q_s[i], q_en[i], q_r[i]);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL div2 cyc %0d got %h want %h", tnow, obs, expv);
      end
    end
    checks++;
    if (bus.Period !== CW'(2) || bus.High_time !== (HT ? CW'(1) : CW'(0))) begin
      errors++;
      $display("FAIL div2_val got P=%0d H=%0d want P=2 H=%0d",
               bus.Period, bus.High_time, HT ? 1 : 0);
    end
  endtask

  task automatic test_div8();
    int t_in = -1, lag = -1, width = 0;
    clear_q();
    add_wave(4, 4, 5, 1'b1);
    for (int i = 0; i < q_s.size(); i++) begin
      step(q_s[i], q_en[i], q_r[i]);
      if (i == 8) t_in = tnow;
      if (t_in >= 0 && lag < 0 && bus.Rise_pulse === 1'b1) lag = tnow - t_in + 1;
      if (t_in >= 0 && i < 16 && bus.Rise_pulse === 1'b1) width++;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL div8 cyc %0d got %h want %h", tnow, obs, expv);
      end
    end
    checks++;
    if (lag !== SS + 1 || width !== 1) begin
      errors++;
      $display("FAIL div8_lag got lag=%0d width=%0d want %0d/1", lag, width, SS + 1);
    end
    checks++;
    if (bus.Period !== CW'(8) || bus.High_time !== (HT ? CW'(4) : CW'(0))) begin
      errors++;
      $display("FAIL div8_val got P=%0d H=%0d want P=8 H=%0d",
               bus.Period, bus.High_time, HT ? 4 : 0);
    end
  endtask

  task automatic test_timeout();
    int t_r = -1, t_to = -1;
    logic to_prev;
    clear_q();
    add_wave(4, 300, 1, 1'b1);
    for (int i = 0; i < q_s.size(); i++) begin
      step(q_s[i], q_en[i], q_r[i]);
      if (bus.Rise_pulse === 1'b1) t_r = tnow;
      if (t_to < 0 && bus.Timeout === 1'b1) t_to = tnow;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL timeout cyc %0d got %h want %h", tnow, obs, expv);
      end
    end
    checks++;
    if (t_r < 0 || t_to - t_r !== MAX + 1) begin
      errors++;
      $display("FAIL timeout_lag got %0d want %0d", t_to - t_r, MAX + 1);
    end
    clear_q();
    add_wave(8, 8, 3, 1'b1);
    t_r = -1;
    for (int i = 0; i < q_s.size(); i++) begin
      to_prev = bus.Timeout;
      step(q_s[i], q_en[i], q_r[i]);
      if (t_r < 0 && bus.Rise_pulse === 1'b1) begin
        t_r = tnow;
        checks++;
        if (to_prev !== 1'b1 || bus.Timeout !== 1'b0) begin
          errors++;
          $display("FAIL timeout_clear got %b->%b want 1->0", to_prev, bus.Timeout);
        end
      end
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL resume cyc %0d got %h want %h", tnow, obs, expv);
      end
    end
    checks++;
    if (bus.Period !== CW'(16)) begin
      errors++;
      $display("FAIL resume_period got %0d want 16", bus.Period);
    end
  endtask

  task automatic test_saturate();
    bit seen = 0;
    clear_q();
    add_wave(128, 128, 3, 1'b1);
    for (int i = 0; i < q_s.size(); i++) begin
      step(q_s[i], q_en[i], q_r[i]);
      if (bus.Period_valid === 1'b1 && bus.Period === CW'(MAX)) seen = 1;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL sat cyc %0d got %h want %h", tnow, obs, expv);
      end
    end
    checks++;
    if (!seen || bus.Period !== CW'(MAX) || bus.Timeout !== 1'b0) begin
      errors++;
      $display("FAIL sat_val got seen=%0d P=%0d T=%b want 1/%0d/0",
               seen, bus.Period, bus.Timeout, MAX);
    end
    clear_q();
    add_wave(150, 150, 2, 1'b1);
    for (int i = 0; i < q_s.size(); i++) begin
      step(q_s[i], q_en[i], q_r[i]);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL p300 cyc %0d got %h want %h", tnow, obs, expv);
      end
    end
    checks++;
    if (bus.Timeout !== 1'b1) begin
      errors++;
      $display("FAIL p300_to got %b want 1", bus.Timeout);
    end
  endtask

  task automatic test_mid_abort();
    int npv = 0;
    clear_q();
    add_wave(4, 4, 3, 1'b1);
    for (int i = 0; i < SS + 6; i++) push(1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < q_s.size(); i++) begin
      step(q_s[i], q_en[i], q_r[i]);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL mid_rst cyc %0d got %h want %h", tnow, obs, expv);
      end
    end
    checks++;
    if (bus.Period !== '0 || bus.Timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_val got P=%0d T=%b want 0/0", bus.Period, bus.Timeout);
    end
    clear_q();
    add_wave(4, 4, 3, 1'b1);
    for (int i = 0; i < SS + 4; i++) push(1'b1, 1'b1, 1'b0);
    add_wave(4, 4, 2, 1'b0);
    for (int i = 0; i < q_s.size(); i++) begin
      step(q_s[i], q_en[i], q_r[i]);
      if (!q_en[i] && bus.Period_valid === 1'b1) npv++;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL mid_en cyc %0d got %h want %h", tnow, obs, expv);
      end
    end
    checks++;
    if (bus.Period !== CW'(8) || npv !== 0) begin
      errors++;
      $display("FAIL mid_en_val got P=%0d pv=%0d want 8/0", bus.Period, npv);
    end
  endtask

  task automatic test_random();
    logic en;
    int   hi, lo;
    clear_q();
    en = 1'b1;
    while (q_s.size() < 3000) begin
      hi = $urandom_range(1, 20);
      lo = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 300)
                                       : $urandom_range(1, 20);
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 60) == 0) push(1'b0, en, 1'b1);
      add_wave(hi, lo, 1, en);
    end
    for (int i = 0; i < q_s.size(); i++) begin
      step(q_s[i], q_en[i], q_r[i]);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random cyc %0d got %h want %h", tnow, obs, expv);
      end
    end
  endtask

  initial begin
    bus.Clk_slow = 1'b0;
    bus.Enable   = 1'b0;
    test_reset();
    test_div2();
    test_div8();
    test_timeout();
    test_saturate();
    test_mid_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
